// File: rtl/wave_capture_pkg.sv
// Shared types and default widths for the wave_capture block.
// Optional feature macro: WAVE_CAPTURE_FORCE_TRIG_EN (used in wave_capture.sv).
package wave_capture_pkg;

  localparam int unsigned ADDRESS_WIDTH_DEF = 8;
  localparam int unsigned DATA_WIDTH_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Read-during-write to the same address returns the previous contents.
module capture_ram
  import wave_capture_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [ADDRESS_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [ADDRESS_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately left out of reset so captures survive it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wave_capture.sv
// Triggered circular capture buffer: FSM, write pointer and trigger logic.
// Define WAVE_CAPTURE_FORCE_TRIG_EN to add the force_trig input.
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     din_valid,
  input  logic                     arm,
`ifdef WAVE_CAPTURE_FORCE_TRIG_EN
  input  logic                     force_trig,
`endif
  input  logic [DATA_WIDTH-1:0]    trig_level,
  input  logic [ADDRESS_WIDTH-1:0] post_count,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] trig_addr
);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH-1:0] remain_q, remain_d;
  logic [ADDRESS_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [DATA_WIDTH-1:0]    prev_sample_q, prev_sample_d;
  logic                     prev_valid_q, prev_valid_d;
  logic                     we;
  logic                     level_hit;
  logic                     trig_hit;

  assign level_hit = prev_valid_q && (prev_sample_q < trig_level) && (din >= trig_level);

`ifdef WAVE_CAPTURE_FORCE_TRIG_EN
  assign trig_hit = level_hit || force_trig;
`else
  assign trig_hit = level_hit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      remain_q      <= '0;
      trig_addr_q   <= '0;
      prev_sample_q <= '0;
      prev_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      remain_q      <= remain_d;
      trig_addr_q   <= trig_addr_d;
      prev_sample_q <= prev_sample_d;
      prev_valid_q  <= prev_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    remain_d      = remain_q;
    trig_addr_d   = trig_addr_q;
    prev_sample_d = prev_sample_q;
    prev_valid_d  = prev_valid_q;
    we            = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d      = ARMED;
          prev_valid_d = 1'b0;
        end
      end
      ARMED: begin
        if (din_valid) begin
          we            = 1'b1;
          wr_ptr_d      = wr_ptr_q + ADDRESS_WIDTH'(1);
          prev_sample_d = din;
          prev_valid_d  = 1'b1;
          if (trig_hit) begin
            trig_addr_d = wr_ptr_q;
            remain_d    = post_count;
            state_d     = (post_count == '0) ? DONE : CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (din_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(1);
          remain_d = remain_q - ADDRESS_WIDTH'(1);
          if (remain_q == ADDRESS_WIDTH'(1)) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  capture_ram #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_ram (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .we_i   (we),
    .waddr_i(wr_ptr_q),
    .wdata_i(din),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  assign busy      = (state_q == ARMED) || (state_q == CAPTURE);
  assign done      = (state_q == DONE);
  assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_wave_capture.sv
// Directed self-checking bench for wave_capture (default 8/8 configuration).
module tb_wave_capture;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       arm;
  logic       force_trig;
  logic [7:0] trig_level;
  logic [7:0] post_count;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic [7:0] trig_addr;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        flag_bad;

  wave_capture #(
    .ADDRESS_WIDTH(8),
    .DATA_WIDTH   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .arm       (arm),
`ifdef WAVE_CAPTURE_FORCE_TRIG_EN
    .force_trig(force_trig),
`endif
    .trig_level(trig_level),
    .post_count(post_count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .trig_addr (trig_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    din       = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    rd_addr = a;
    tick();
    chk(tag, rd_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; arm = 1'b0; force_trig = 1'b0;
    trig_level = '0; post_count = '0; rd_addr = '0;
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_trig_addr", trig_addr, 0);
    #10 rst_n = 1'b1;

    // Ramp with no arm: FSM stays idle, pointer must not move.
    flag_bad = 1'b0;
    for (int i = 0; i < 256; i++) begin
      send(8'(i));
      if (busy !== 1'b0 || done !== 1'b0) flag_bad = 1'b1;
    end
    chk("idle_ramp_flags", flag_bad, 0);

    // Level trigger at 0x80, four post samples.
    trig_level = 8'h80;
    post_count = 8'd4;
    pulse_arm();
    chk("arm_busy", busy, 1);
    for (int i = 0; i <= 8'h83; i++) send(8'(i));
    chk("lvl_not_done_yet", done, 0);
    send(8'h84);
    chk("lvl_done", done, 1);
    chk("lvl_busy_low", busy, 0);
    chk("lvl_trig_addr", trig_addr, 128);
    for (int i = 0; i < 5; i++) read_chk("lvl_read", 8'(128 + i), 8'(8'h80 + i));
    // Samples while DONE must not be stored.
    for (int i = 0; i < 3; i++) send(8'hAA);
    chk("done_holds", done, 1);

    // First-sample rule: 0xFF first, then 0x05, 0x10 triggers (post_count 0).
    trig_level = 8'h10;
    post_count = 8'd0;
    pulse_arm();
    send(8'hFF);
    chk("first_no_trig_busy", busy, 1);
    chk("first_no_trig_done", done, 0);
    send(8'h05);
    chk("low_no_trig", done, 0);
    send(8'h10);
    chk("first_rule_done", done, 1);
    chk("first_rule_trig_addr", trig_addr, 135);
    read_chk("first_rule_ff", 8'd133, 8'hFF);
    read_chk("first_rule_05", 8'd134, 8'h05);
    read_chk("first_rule_10", 8'd135, 8'h10);

    // Wrap-around: trigger at 250, post_count 255, with stall and ignored arm.
    trig_level = 8'h80;
    post_count = 8'd255;
    pulse_arm();
    for (int i = 136; i < 250; i++) send(8'h00);
    send(8'h90);
    chk("wrap_capture_busy", busy, 1);
    for (int k = 1; k <= 10; k++) send(8'(k));
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    chk("stall_arm_busy", busy, 1);
    chk("stall_arm_done", done, 0);
    for (int k = 11; k <= 254; k++) send(8'(k));
    chk("wrap_not_done_yet", done, 0);
    send(8'd255);
    chk("wrap_done", done, 1);
    chk("wrap_trig_addr", trig_addr, 250);
    read_chk("wrap_trig_kept", 8'd250, 8'h90);
    read_chk("wrap_s5_at_255", 8'd255, 8'd5);
    read_chk("wrap_s6_at_0", 8'd0, 8'd6);
    read_chk("wrap_last_at_249", 8'd249, 8'd255);
    pulse_arm();
    chk("rearm_busy", busy, 1);
    chk("rearm_done", done, 0);

    // Reset mid-capture: trigger at 251, then asynchronous reset.
    post_count = 8'd10;
    send(8'h00);
    send(8'h90);
    send(8'h91);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_trig_addr", trig_addr, 0);
    tick();
    rst_n = 1'b1;
    read_chk("ram_survives_reset", 8'd251, 8'h90);
    post_count = 8'd0;
    pulse_arm();
    send(8'h00);
    send(8'h80);
    chk("post_rst_done", done, 1);
    chk("post_rst_trig_addr", trig_addr, 1);
    read_chk("post_rst_addr0", 8'd0, 8'h00);
    read_chk("post_rst_addr1", 8'd1, 8'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
